// File: rtl/tryx_axi_resp_tracker.sv
// Per-core AXI response tracker: injects each core's armed user value on AW/AR, folds
// B and R responses into one-cycle per-core error reports, and counts outstanding requests.
module tryx_axi_resp_tracker #(
  parameter int NB_CORES       = 0,
  parameter int AXI_ID_WIDTH   = 0,
  parameter int AXI_USER_WIDTH = 0,
  parameter int CORE_ID_LSB    = 0,
  parameter int MAX_OUTST      = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NB_CORES-1:0][AXI_USER_WIDTH-1:0] axuser_i,
  input  logic                                    aw_valid_i,
  input  logic                                    aw_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]                 aw_id_i,
  output logic [AXI_USER_WIDTH-1:0]               aw_user_o,
  input  logic                                    ar_valid_i,
  input  logic                                    ar_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]                 ar_id_i,
  output logic [AXI_USER_WIDTH-1:0]               ar_user_o,
  input  logic                                    b_valid_i,
  input  logic                                    b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]                 b_id_i,
  input  logic [1:0]                              b_resp_i,
  input  logic                                    r_valid_i,
  input  logic                                    r_ready_i,
  input  logic                                    r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]                 r_id_i,
  input  logic [1:0]                              r_resp_i,
  output logic [NB_CORES-1:0]                     xresp_valid_o,
  output logic [NB_CORES-1:0]                     xresp_decerr_o,
  output logic [NB_CORES-1:0]                     xresp_slverr_o,
  output logic [NB_CORES-1:0]                     outst_full_o,
  output logic [NB_CORES-1:0]                     outst_ovf_o
);

  localparam int IDX_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  localparam int CNT_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST + 1) : 1;

  if (NB_CORES <= 0) begin : g_bad_nb_cores
    $fatal(1, "tryx_axi_resp_tracker: NB_CORES must be greater than 0");
  end
  if (MAX_OUTST < 1) begin : g_bad_max_outst
    $fatal(1, "tryx_axi_resp_tracker: MAX_OUTST must be at least 1");
  end

  // Handshake semantics: a beat or request exists only in a cycle where valid && ready.
  // Rank encoding: 0 = OKAY/EXOKAY, 1 = SLVERR, 2 = DECERR; merging keeps the maximum.
  function automatic logic [1:0] rank_of(input logic [1:0] resp);
    case (resp)
      2'b11:   rank_of = 2'd2;
      2'b10:   rank_of = 2'd1;
      default: rank_of = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] rank_max(input logic [1:0] a, input logic [1:0] b);
    rank_max = (a > b) ? a : b;
  endfunction

  logic [IDX_W-1:0] aw_idx, ar_idx, b_idx, r_idx;
  assign aw_idx = aw_id_i[CORE_ID_LSB +: IDX_W];
  assign ar_idx = ar_id_i[CORE_ID_LSB +: IDX_W];
  assign b_idx  = b_id_i[CORE_ID_LSB +: IDX_W];
  assign r_idx  = r_id_i[CORE_ID_LSB +: IDX_W];

  logic [NB_CORES-1:0] aw_hit, ar_hit, b_hit, r_hit;

  // Indices at or above NB_CORES match no core: user reads 0 and nothing is tracked.
  always_comb begin
    aw_user_o = '0;
    ar_user_o = '0;
    aw_hit    = '0;
    ar_hit    = '0;
    b_hit     = '0;
    r_hit     = '0;
    for (int c = 0; c < NB_CORES; c++) begin
      if (aw_idx == IDX_W'(c)) aw_user_o = axuser_i[c];
      if (ar_idx == IDX_W'(c)) ar_user_o = axuser_i[c];
      aw_hit[c] = aw_valid_i & aw_ready_i & (aw_idx == IDX_W'(c));
      ar_hit[c] = ar_valid_i & ar_ready_i & (ar_idx == IDX_W'(c));
      b_hit[c]  = b_valid_i & b_ready_i & (b_idx == IDX_W'(c));
      r_hit[c]  = r_valid_i & r_ready_i & (r_idx == IDX_W'(c));
    end
  end

  logic [NB_CORES-1:0][1:0]       racc_q, racc_d;
  logic [NB_CORES-1:0]            out_v_q, out_v_d;
  logic [NB_CORES-1:0][1:0]       out_rank_q, out_rank_d;
  logic [NB_CORES-1:0]            pend_v_q, pend_v_d;
  logic [NB_CORES-1:0][1:0]       pend_rank_q, pend_rank_d;
  logic [NB_CORES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NB_CORES-1:0]            full_q, full_d;
  logic [NB_CORES-1:0]            ovf_q, ovf_d;

  logic [1:0] b_rank, r_merged, b_part, r_part;
  logic       r_done;
  logic [1:0] inc, dec;
  int         nxt;

  always_comb begin
    racc_d      = racc_q;
    out_v_d     = '0;
    out_rank_d  = '0;
    pend_v_d    = pend_v_q;
    pend_rank_d = pend_rank_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    ovf_d       = ovf_q;
    b_rank      = rank_of(b_resp_i);
    r_merged    = '0;
    r_done      = 1'b0;
    b_part      = '0;
    r_part      = '0;
    inc         = '0;
    dec         = '0;
    nxt         = 0;
    for (int c = 0; c < NB_CORES; c++) begin
      r_merged = rank_max(racc_q[c], rank_of(r_resp_i));
      r_done   = r_hit[c] & r_last_i;
      if (r_hit[c]) racc_d[c] = r_last_i ? 2'd0 : r_merged;

      b_part = b_hit[c] ? b_rank : 2'd0;
      r_part = r_done ? r_merged : 2'd0;

      // A completion landing while a report is held folds into it; the merged report issues once.
      if (pend_v_q[c]) begin
        out_v_d[c]     = 1'b1;
        out_rank_d[c]  = rank_max(pend_rank_q[c], rank_max(b_part, r_part));
        pend_v_d[c]    = 1'b0;
        pend_rank_d[c] = 2'd0;
      end else if (b_hit[c] && r_done) begin
        out_v_d[c]     = 1'b1;
        out_rank_d[c]  = b_part;
        pend_v_d[c]    = 1'b1;
        pend_rank_d[c] = r_part;
      end else if (b_hit[c] || r_done) begin
        out_v_d[c]     = 1'b1;
        out_rank_d[c]  = rank_max(b_part, r_part);
      end

      inc = 2'(aw_hit[c]) + 2'(ar_hit[c]);
      dec = 2'(b_hit[c]) + 2'(r_done);
      nxt = int'(cnt_q[c]) + int'(inc) - int'(dec);
      if (nxt > MAX_OUTST) nxt = MAX_OUTST;
      if (nxt < 0) nxt = 0;
      cnt_d[c]  = CNT_W'(nxt);
      full_d[c] = (cnt_d[c] == CNT_W'(MAX_OUTST));
      ovf_d[c]  = ovf_q[c] | ((inc != 2'd0) && (cnt_q[c] == CNT_W'(MAX_OUTST)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      racc_q      <= '0;
      out_v_q     <= '0;
      out_rank_q  <= '0;
      pend_v_q    <= '0;
      pend_rank_q <= '0;
      cnt_q       <= '0;
      full_q      <= '0;
      ovf_q       <= '0;
    end else begin
      racc_q      <= racc_d;
      out_v_q     <= out_v_d;
      out_rank_q  <= out_rank_d;
      pend_v_q    <= pend_v_d;
      pend_rank_q <= pend_rank_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    xresp_valid_o  = out_v_q;
    xresp_decerr_o = '0;
    xresp_slverr_o = '0;
    for (int c = 0; c < NB_CORES; c++) begin
      xresp_decerr_o[c] = out_v_q[c] & (out_rank_q[c] == 2'd2);
      xresp_slverr_o[c] = out_v_q[c] & (out_rank_q[c] == 2'd1);
    end
  end

  assign outst_full_o = full_q;
  assign outst_ovf_o  = ovf_q;

endmodule

// File: tb/tb_tryx_axi_resp_tracker.sv
// Table-driven bench for tryx_axi_resp_tracker: per-cycle stimulus rows with hand-computed
// report/counter expectations, plus a reset-mid-burst sequence.
module tb_tryx_axi_resp_tracker;
  localparam int NB   = 5;
  localparam int IDW  = 6;
  localparam int UW   = 8;
  localparam int LSB  = 2;
  localparam int MAXO = 2;

  localparam logic [1:0] HS = 2'b11;
  localparam logic [1:0] NO = 2'b00;
  localparam logic [2:0] R_NONE  = 3'b000;
  localparam logic [2:0] R_BEAT  = 3'b110;
  localparam logic [2:0] R_LAST  = 3'b111;
  localparam logic [2:0] R_STALL = 3'b101;
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] C0 = 5'b00001;
  localparam logic [4:0] C1 = 5'b00010;
  localparam logic [4:0] C2 = 5'b00100;
  localparam logic [4:0] C3 = 5'b01000;
  localparam logic [4:0] C4 = 5'b10000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0][UW-1:0] axuser;
  logic aw_valid, aw_ready, ar_valid, ar_ready, b_valid, b_ready, r_valid, r_ready, r_last;
  logic [IDW-1:0] aw_id, ar_id, b_id, r_id;
  logic [1:0] b_resp, r_resp;
  logic [UW-1:0] aw_user, ar_user;
  logic [NB-1:0] xv, xd, xs, full, ovf;

  tryx_axi_resp_tracker #(
    .NB_CORES(NB), .AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW), .CORE_ID_LSB(LSB), .MAX_OUTST(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .axuser_i(axuser),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_id_i(aw_id), .aw_user_o(aw_user),
    .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_id_i(ar_id), .ar_user_o(ar_user),
    .b_valid_i(b_valid), .b_ready_i(b_ready), .b_id_i(b_id), .b_resp_i(b_resp),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last), .r_id_i(r_id), .r_resp_i(r_resp),
    .xresp_valid_o(xv), .xresp_decerr_o(xd), .xresp_slverr_o(xs),
    .outst_full_o(full), .outst_ovf_o(ovf)
  );

  typedef struct {
    string      name;
    logic [1:0] aw;  logic [2:0] awc;
    logic [1:0] ar;  logic [2:0] arc;
    logic [1:0] b;   logic [2:0] bc; logic [1:0] bresp;
    logic [2:0] r;   logic [2:0] rc; logic [1:0] rresp;
    logic [4:0] ev, ed, es, ef, eo;
  } vec_t;

  vec_t vecs[$];
  logic [24:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input string n, input logic [1:0] aw, input logic [2:0] awc,
                              input logic [1:0] ar, input logic [2:0] arc,
                              input logic [1:0] b, input logic [2:0] bc, input logic [1:0] bresp,
                              input logic [2:0] r, input logic [2:0] rc, input logic [1:0] rresp,
                              input logic [4:0] ev, input logic [4:0] ed, input logic [4:0] es,
                              input logic [4:0] ef, input logic [4:0] eo);
    vec_t v;
    v.name = n; v.aw = aw; v.awc = awc; v.ar = ar; v.arc = arc;
    v.b = b; v.bc = bc; v.bresp = bresp; v.r = r; v.rc = rc; v.rresp = rresp;
    v.ev = ev; v.ed = ed; v.es = es; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  // Core index lives in bits [4:2]; the other bits carry unrelated tag content.
  function automatic logic [IDW-1:0] id_of(input logic [2:0] c);
    return {1'b1, c, 2'b10};
  endfunction

  function automatic logic [UW-1:0] user_of(input logic [2:0] c);
    return (int'(c) < NB) ? axuser[c] : '0;
  endfunction

  // scoreboard compare
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    aw_valid = v.aw[1]; aw_ready = v.aw[0]; aw_id = id_of(v.awc);
    ar_valid = v.ar[1]; ar_ready = v.ar[0]; ar_id = id_of(v.arc);
    b_valid  = v.b[1];  b_ready  = v.b[0];  b_id  = id_of(v.bc); b_resp = v.bresp;
    r_valid  = v.r[2];  r_ready  = v.r[1];  r_last = v.r[0]; r_id = id_of(v.rc); r_resp = v.rresp;
  endtask

  task automatic drive_idle();
    drive(mk("idle", NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z, Z, Z, Z, Z));
  endtask

  initial begin
    logic [24:0] e;
    axuser[0] = 8'h10; axuser[1] = 8'h05; axuser[2] = 8'h12; axuser[3] = 8'h13; axuser[4] = 8'h14;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.valid", 32'(xv), 32'(Z));
    chk("reset.decerr", 32'(xd), 32'(Z));
    chk("reset.slverr", 32'(xs), 32'(Z));
    chk("reset.full", 32'(full), 32'(Z));
    chk("reset.ovf", 32'(ovf), 32'(Z));
    rst_n = 1'b1;

    //              name            aw  awc   ar  arc   b   bc  bresp  r       rc    rresp  valid dec slv full ovf
    vecs.push_back(mk("idle0",      NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("aw_c2",      HS, 3'd2, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("b_c2_slv",   NO, 3'd2, NO, 3'd0, HS, 3'd2, 2'b10, R_NONE, 3'd0, 2'b00, C2, Z,  C2, Z,  Z));
    vecs.push_back(mk("after_b",    NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("ar_c0",      NO, 3'd0, HS, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("r_c0_b1",    NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_BEAT, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("r_c0_b2",    NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_BEAT, 3'd0, 2'b11, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("r_c0_b3",    NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_BEAT, 3'd0, 2'b10, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("r_c0_last",  NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_LAST, 3'd0, 2'b00, C0, C0, Z,  Z,  Z));
    vecs.push_back(mk("after_r0",   NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("ar_c4",      NO, 3'd0, HS, 3'd4, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("r_c4_stall", NO, 3'd0, NO, 3'd4, NO, 3'd0, 2'b00, R_STALL,3'd4, 2'b11, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("r_c4_last",  NO, 3'd0, NO, 3'd4, NO, 3'd0, 2'b00, R_LAST, 3'd4, 2'b00, C4, Z,  Z,  Z,  Z));
    vecs.push_back(mk("awar_c1",    HS, 3'd1, HS, 3'd1, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  C1, Z));
    vecs.push_back(mk("b_r_c1",     NO, 3'd1, NO, 3'd1, HS, 3'd1, 2'b00, R_LAST, 3'd1, 2'b11, C1, Z,  Z,  Z,  Z));
    vecs.push_back(mk("pend_c1",    NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, C1, C1, Z,  Z,  Z));
    vecs.push_back(mk("after_pend", NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("awar_c1_2",  HS, 3'd1, HS, 3'd1, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  C1, Z));
    vecs.push_back(mk("b_rslv_c1",  NO, 3'd1, NO, 3'd1, HS, 3'd1, 2'b00, R_LAST, 3'd1, 2'b10, C1, Z,  Z,  Z,  Z));
    vecs.push_back(mk("b_dec_merge",NO, 3'd1, NO, 3'd1, HS, 3'd1, 2'b11, R_NONE, 3'd1, 2'b00, C1, C1, Z,  Z,  Z));
    vecs.push_back(mk("no_third",   NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("ar_c3_1",    NO, 3'd0, HS, 3'd3, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  Z));
    vecs.push_back(mk("ar_c3_2",    NO, 3'd0, HS, 3'd3, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  C3, Z));
    vecs.push_back(mk("ar_c3_3",    NO, 3'd0, HS, 3'd3, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  C3, C3));
    vecs.push_back(mk("r_c3_last1", NO, 3'd0, NO, 3'd3, NO, 3'd0, 2'b00, R_LAST, 3'd3, 2'b00, C3, Z,  Z,  Z,  C3));
    vecs.push_back(mk("r_c3_last2", NO, 3'd0, NO, 3'd3, NO, 3'd0, 2'b00, R_LAST, 3'd3, 2'b10, C3, Z,  C3, Z,  C3));
    vecs.push_back(mk("idle_c3",    NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  C3));
    vecs.push_back(mk("bad_idx",    HS, 3'd6, HS, 3'd7, HS, 3'd6, 2'b11, R_LAST, 3'd5, 2'b11, Z,  Z,  Z,  Z,  C3));
    vecs.push_back(mk("after_bad",  NO, 3'd6, NO, 3'd7, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  C3));
    vecs.push_back(mk("aw_ar_r_c0", HS, 3'd0, HS, 3'd0, NO, 3'd0, 2'b00, R_LAST, 3'd0, 2'b10, C0, Z,  C0, Z,  C3));
    vecs.push_back(mk("b_c0_dec",   NO, 3'd0, NO, 3'd0, HS, 3'd0, 2'b11, R_NONE, 3'd0, 2'b00, C0, C0, Z,  Z,  C3));
    vecs.push_back(mk("idle_end",   NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z,  Z,  Z,  Z,  C3));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk({vecs[i].name, ".aw_user"}, 32'(aw_user), 32'(user_of(vecs[i].awc)));
      chk({vecs[i].name, ".ar_user"}, 32'(ar_user), 32'(user_of(vecs[i].arc)));
      exp_q.push_back({vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].ef, vecs[i].eo});
      @(negedge clk);
      e = exp_q.pop_front();
      chk({vecs[i].name, ".valid"}, 32'(xv), 32'(e[24:20]));
      chk({vecs[i].name, ".decerr"}, 32'(xd), 32'(e[19:15]));
      chk({vecs[i].name, ".slverr"}, 32'(xs), 32'(e[14:10]));
      chk({vecs[i].name, ".full"}, 32'(full), 32'(e[9:5]));
      chk({vecs[i].name, ".ovf"}, 32'(ovf), 32'(e[4:0]));
    end

    // Reset asserted with a read accumulating on core 2 and a held report on core 1.
    drive(mk("rst_a", HS, 3'd1, HS, 3'd2, NO, 3'd0, 2'b00, R_NONE, 3'd0, 2'b00, Z, Z, Z, Z, Z));
    @(negedge clk);
    drive(mk("rst_b", NO, 3'd0, HS, 3'd1, NO, 3'd0, 2'b00, R_BEAT, 3'd2, 2'b11, Z, Z, Z, Z, Z));
    @(negedge clk);
    drive(mk("rst_c", NO, 3'd0, NO, 3'd0, HS, 3'd1, 2'b00, R_LAST, 3'd1, 2'b11, Z, Z, Z, Z, Z));
    @(negedge clk);
    chk("rst_seq.b_report", 32'(xv), 32'(C1));
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_seq.async_valid", 32'(xv), 32'(Z));
    chk("rst_seq.async_ovf", 32'(ovf), 32'(Z));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_seq.pend_dropped", 32'(xv), 32'(Z));
    drive(mk("rst_d", NO, 3'd0, NO, 3'd0, NO, 3'd0, 2'b00, R_LAST, 3'd2, 2'b00, Z, Z, Z, Z, Z));
    @(negedge clk);
    chk("rst_seq.racc_valid", 32'(xv), 32'(C2));
    chk("rst_seq.racc_decerr", 32'(xd), 32'(Z));
    chk("rst_seq.racc_full", 32'(full), 32'(Z));
    drive_idle();
    @(negedge clk);
    chk("rst_seq.quiet", 32'(xv), 32'(Z));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
